cpu_datapath_core: RTL and testbench
====================================

# cpu_datapath_core

Scalar-plus-tensor datapath for the tiny tensor core CPU. It decodes one 32-bit instruction per clock. It executes 8-bit ALU operations against a 256-entry CPU register file, and loads and updates a 32-byte tensor register file that feeds an external 4x4 tensor core. The block sits between the instruction source and the tensor core. The external multiplier stays outside this block and is reached through the `tensor_a_out`/`tensor_b_out`/`tensor_product_in` ports.

## Interface
- No parameters; all widths are fixed.
- `clock_in`  input  1  — single clock; all state updates on the rising edge.
- `reset_in`  input  1  — asynchronous, active-high reset.
- `instruction_in`  input  32  — current instruction, sampled at each rising edge.
  - [31:24] dest register / tensor address ([28:24])
  - [23:16] immediate operand1 / tensor data
  - [15:8] source register
  - [7:0] opcode
- `alu_output_out`  output  8  — registered ALU result.
- `tensor_read_data_out`  output  256  — full tensor register file contents, combinational from state.
- `tensor_a_out`  output  128  — bits [255:128] of `tensor_read_data_out` (matrix A).
- `tensor_b_out`  output  128  — bits [127:0] of `tensor_read_data_out` (matrix B).
- `tensor_product_in`  input  128  — A×B result from the external tensor core, same byte layout as A.

## Operation
- **CPU register file.** 256 x 8-bit registers, no hardwired zero.
  - Read address is `instruction_in[15:8]`; the read is combinational.
  - The write is synchronous.
- **ALU operands.**
  - op1 = `instruction_in[23:16]` (immediate).
  - op2 = `rf[instruction_in[15:8]]`.
- **Opcodes.** For opcodes 0-4 and 7, result R is written to `rf[instruction_in[31:24]]` and to the `alu_output_out` register at the same edge. All arithmetic is modulo 256.
  - 0 ADD: op1+op2.
  - 1 SUB: op1−op2.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 7 LDI: R = op1.
  - 5 TBULK: tensor bytes [255:128] ← `tensor_product_in`; bytes [127:0] unchanged.
  - 6 TWRITE: tensor register at address `instruction_in[28:24]` ← `instruction_in[23:16]`. Bits [31:29] are ignored.
  - 8-255: no operation.
- **Opcodes with no CPU register write.** For opcodes 5, 6 and 8-255:
  - No CPU register is written.
  - `alu_output_out` holds its previous value.
  - No tensor write occurs, except for opcodes 5 and 6 as above.
- **Tensor register file.** 32 x 8-bit registers.
  - Address a occupies bits [(31−a)*8 +: 8], so address 0 is the most-significant byte.
  - Addresses 0-15 form matrix A, row-major (a = 4·row + col).
  - Addresses 16-31 form matrix B in the same order.
- **Read-during-write.** A read of a register being written in the same cycle returns the old value. There is no bypass, so a result is visible to the next instruction.
- **Exclusive writes.** Bulk and single-byte tensor writes are mutually exclusive because their opcodes differ.

## Timing
- **Reset.** While `reset_in` is high, asynchronously:
  - all 256 CPU registers = 0;
  - all 32 tensor registers = 0;
  - `alu_output_out` = 0.
- **Reset mid-operation.** Outputs clear immediately, without waiting for a clock edge. The first edge after deassertion executes the instruction present at that edge.
- **Latency.**
  - ALU result appears on `alu_output_out` one edge after the instruction is presented.
  - The destination register is updated at the same edge.
- **Tensor writes.**
  - Visible on `tensor_read_data_out`, `tensor_a_out` and `tensor_b_out` right after the writing edge.
  - `tensor_product_in` is sampled at the TBULK edge. It may combinationally depend on `tensor_a_out`/`tensor_b_out`; no loop exists because the path passes through a register.
- **Throughput.** One instruction per cycle; no stalls or handshake.

## Test plan
- **Reset.** Pulse `reset_in` between edges → `alu_output_out` = 0x00 and `tensor_read_data_out` = 0 immediately. Then read registers 0-255 via ADD with immediate 0 → every result is 0.
- **LDI then ADD.**
  - LDI {dest=3, imm=25, op=7} → `alu_output_out` = 25.
  - ADD {dest=4, imm=10, src=3, op=0} → 35, and rf[4] = 35.
- **SUB and logic.** With rf[3] = 25:
  - SUB {imm=10, src=3} → 0xF1 (wrap).
  - AND imm 0x0F → 0x09.
  - XOR imm 0xFF → 0xE6.
  - Opcode 0x80 → output holds, no register changes.
- **TWRITE.**
  - TWRITE with instr[31:24] = 0xE0 (addr 0), data 0xAB → `tensor_read_data_out[255:248]` = 0xAB.
  - Addr 31, data 0x5C → [7:0] = 0x5C.
  - `alu_output_out` is unchanged throughout.
- **TBULK.** Load A and B with distinct bytes, drive `tensor_product_in` = 0x0102…10, issue TBULK → `tensor_a_out` = 0x0102…10 and `tensor_b_out` is unchanged.
- **Back-to-back dependency.** LDI r7=200, then ADD {imm=100, src=7} on the next cycle → 44 (300 mod 256).

Source files
------------

// File: rtl/cpu_datapath_core.sv
// rtl/cpu_datapath_core.sv - scalar ALU + 256x8 register file + 32-byte tensor register file datapath
module cpu_datapath_core (
    input  logic         clock_in,
    input  logic         reset_in,
    input  logic [31:0]  instruction_in,
    output logic [7:0]   alu_output_out,
    output logic [255:0] tensor_read_data_out,
    output logic [127:0] tensor_a_out,
    output logic [127:0] tensor_b_out,
    input  logic [127:0] tensor_product_in
);

    localparam logic [7:0] OP_ADD    = 8'd0;
    localparam logic [7:0] OP_SUB    = 8'd1;
    localparam logic [7:0] OP_AND    = 8'd2;
    localparam logic [7:0] OP_OR     = 8'd3;
    localparam logic [7:0] OP_XOR    = 8'd4;
    localparam logic [7:0] OP_TBULK  = 8'd5;
    localparam logic [7:0] OP_TWRITE = 8'd6;
    localparam logic [7:0] OP_LDI    = 8'd7;

    logic [7:0]   dest;
    logic [7:0]   imm;
    logic [7:0]   src;
    logic [7:0]   opcode;
    logic [4:0]   tensor_addr;
    logic [7:0]   tensor_bit_base;

    logic [7:0]   rf [256];
    logic [255:0] tensor_q;
    logic [7:0]   op2;
    logic [7:0]   alu_result;
    logic         alu_write;
    logic         tbulk_write;
    logic         twrite_write;

    assign dest        = instruction_in[31:24];
    assign imm         = instruction_in[23:16];
    assign src         = instruction_in[15:8];
    assign opcode      = instruction_in[7:0];
    assign tensor_addr = instruction_in[28:24];

    // Address a lives at byte (31-a); for a 5-bit address that is simply ~a.
    assign tensor_bit_base = {~tensor_addr, 3'b000};

    assign op2 = rf[src];

    always_comb begin
        alu_result   = 8'h00;
        alu_write    = 1'b0;
        tbulk_write  = 1'b0;
        twrite_write = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_result = imm + op2;
                alu_write  = 1'b1;
            end
            OP_SUB: begin
                alu_result = imm - op2;
                alu_write  = 1'b1;
            end
            OP_AND: begin
                alu_result = imm & op2;
                alu_write  = 1'b1;
            end
            OP_OR: begin
                alu_result = imm | op2;
                alu_write  = 1'b1;
            end
            OP_XOR: begin
                alu_result = imm ^ op2;
                alu_write  = 1'b1;
            end
            OP_LDI: begin
                alu_result = imm;
                alu_write  = 1'b1;
            end
            OP_TBULK:  tbulk_write  = 1'b1;
            OP_TWRITE: twrite_write = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < 256; i++) begin
                rf[i] <= 8'h00;
            end
            alu_output_out <= 8'h00;
        end else if (alu_write) begin
            rf[dest]       <= alu_result;
            alu_output_out <= alu_result;
        end
    end

    // Product is registered here, so a combinational A*B path back from the tensor core cannot loop.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            tensor_q <= '0;
        end else if (tbulk_write) begin
            tensor_q[255:128] <= tensor_product_in;
        end else if (twrite_write) begin
            tensor_q[tensor_bit_base +: 8] <= imm;
        end
    end

    assign tensor_read_data_out = tensor_q;
    assign tensor_a_out         = tensor_q[255:128];
    assign tensor_b_out         = tensor_q[127:0];

endmodule

// File: tb/tb_cpu_datapath_core.sv
// tb/tb_cpu_datapath_core.sv - directed table-driven bench for cpu_datapath_core
module tb_cpu_datapath_core;

    logic         clock_in;
    logic         reset_in;
    logic [31:0]  instruction_in;
    logic [7:0]   alu_output_out;
    logic [255:0] tensor_read_data_out;
    logic [127:0] tensor_a_out;
    logic [127:0] tensor_b_out;
    logic [127:0] tensor_product_in;

    cpu_datapath_core dut (
        .clock_in             (clock_in),
        .reset_in             (reset_in),
        .instruction_in       (instruction_in),
        .alu_output_out       (alu_output_out),
        .tensor_read_data_out (tensor_read_data_out),
        .tensor_a_out         (tensor_a_out),
        .tensor_b_out         (tensor_b_out),
        .tensor_product_in    (tensor_product_in)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  exp_alu;
    } vec_t;

    vec_t         vecs [19];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [255:0] exp_tensor;
    logic [127:0] product;
    logic [7:0]   exp_reg;

    function automatic logic [31:0] ins(input logic [7:0] d, input logic [7:0] i,
                                        input logic [7:0] s, input logic [7:0] op);
        return {d, i, s, op};
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %064h expected %064h", name, act, exp);
    endtask

    task automatic run(input logic [31:0] instr);
        @(negedge clock_in);
        instruction_in = instr;
        @(posedge clock_in);
        #1;
    endtask

    initial begin
        reset_in          = 1'b1;
        instruction_in    = 32'h0000_00FF;
        tensor_product_in = '0;

        vecs[0]  = '{ins(8'd3,   8'd25,  8'd0,   8'd7),  8'd25};
        vecs[1]  = '{ins(8'd4,   8'd10,  8'd3,   8'd0),  8'd35};
        vecs[2]  = '{ins(8'd5,   8'd0,   8'd4,   8'd0),  8'd35};
        vecs[3]  = '{ins(8'd6,   8'd10,  8'd3,   8'd1),  8'hF1};
        vecs[4]  = '{ins(8'd8,   8'h0F,  8'd3,   8'd2),  8'h09};
        vecs[5]  = '{ins(8'd9,   8'hC0,  8'd3,   8'd3),  8'hD9};
        vecs[6]  = '{ins(8'd10,  8'hFF,  8'd3,   8'd4),  8'hE6};
        vecs[7]  = '{ins(8'd3,   8'd0,   8'd0,   8'h80), 8'hE6};
        vecs[8]  = '{ins(8'd11,  8'd0,   8'd3,   8'd0),  8'd25};
        vecs[9]  = '{ins(8'd13,  8'd0,   8'd6,   8'd0),  8'hF1};
        vecs[10] = '{ins(8'd7,   8'd200, 8'd0,   8'd7),  8'd200};
        vecs[11] = '{ins(8'd12,  8'd100, 8'd7,   8'd0),  8'd44};
        vecs[12] = '{ins(8'd255, 8'd1,   8'd255, 8'd0),  8'd1};
        vecs[13] = '{ins(8'd0,   8'd0,   8'd255, 8'd0),  8'd1};
        vecs[14] = '{ins(8'd0,   8'd9,   8'd0,   8'hFF), 8'd1};
        vecs[15] = '{ins(8'd20,  8'd5,   8'd20,  8'd0),  8'd5};
        vecs[16] = '{ins(8'd20,  8'd5,   8'd20,  8'd0),  8'd10};
        vecs[17] = '{ins(8'd21,  8'd0,   8'd0,   8'd7),  8'd0};
        vecs[18] = '{ins(8'd22,  8'd0,   8'd7,   8'd1),  8'h38};

        #2;
        check8("reset_alu", alu_output_out, 8'h00);
        check256("reset_tensor", tensor_read_data_out, '0);
        @(negedge clock_in);
        reset_in = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run(vecs[i].instr);
            check8($sformatf("vec%0d_alu", i), alu_output_out, vecs[i].exp_alu);
        end

        // Single-byte tensor writes; alu output must keep 0x38 throughout.
        exp_tensor = '0;
        run(ins(8'hE0, 8'hAB, 8'd0, 8'd6));
        exp_tensor[255:248] = 8'hAB;
        check256("twrite_addr0", tensor_read_data_out, exp_tensor);
        check8("twrite_alu_hold0", alu_output_out, 8'h38);
        run(ins(8'd31, 8'h5C, 8'd0, 8'd6));
        exp_tensor[7:0] = 8'h5C;
        check256("twrite_addr31", tensor_read_data_out, exp_tensor);
        check8("twrite_alu_hold31", alu_output_out, 8'h38);

        for (int a = 0; a < 32; a++) begin
            run(ins({3'b101, 5'(a)}, 8'h40 + 8'(a), 8'd0, 8'd6));
            exp_tensor[(31 - a) * 8 +: 8] = 8'h40 + 8'(a);
        end
        check256("twrite_fill", tensor_read_data_out, exp_tensor);
        check256("twrite_a_port", {tensor_a_out, tensor_b_out}, exp_tensor);
        check8("twrite_fill_alu_hold", alu_output_out, 8'h38);

        product = 128'h0102030405060708090A0B0C0D0E0F10;
        tensor_product_in = product;
        run(ins(8'h00, 8'h00, 8'h00, 8'd5));
        tensor_product_in = '0;
        check256("tbulk_a", {128'h0, tensor_a_out}, {128'h0, product});
        check256("tbulk_b", {128'h0, tensor_b_out}, {128'h0, exp_tensor[127:0]});
        check256("tbulk_full", tensor_read_data_out, {product, exp_tensor[127:0]});
        check8("tbulk_alu_hold", alu_output_out, 8'h38);

        // TWRITE dest field 0xA5 must not have touched rf[0xA5].
        run(ins(8'd1, 8'd0, 8'hA5, 8'd0));
        check8("twrite_no_rf", alu_output_out, 8'h00);
        run(ins(8'd1, 8'h3C, 8'd0, 8'd7));
        check8("ldi_pre_reset", alu_output_out, 8'h3C);

        // Reset pulse between edges clears outputs immediately.
        @(negedge clock_in);
        instruction_in = ins(8'd1, 8'h77, 8'd0, 8'd7);
        reset_in = 1'b1;
        #1;
        check8("midreset_alu", alu_output_out, 8'h00);
        check256("midreset_tensor", tensor_read_data_out, '0);
        #1;
        reset_in = 1'b0;
        @(posedge clock_in);
        #1;
        check8("post_reset_first_instr", alu_output_out, 8'h77);

        for (int r = 0; r < 256; r++) begin
            run(ins(8'(r), 8'd0, 8'(r), 8'd0));
            exp_reg = (r == 1) ? 8'h77 : 8'h00;
            check8($sformatf("rf_after_reset_%0d", r), alu_output_out, exp_reg);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
